// File: rtl/adder.sv
// Full-adder bit cell plus a 4-bit LSB-first serial adder built from the same cell.
// The slice is pure combinational logic; the engine adds op_a + op_b + cin over four clocks.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result/cout hold the last completed sum
// RUN   | one operand bit per clock, bit counter 0..3, LSB first
module adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    output logic       sum,
    output logic       c,
    input  logic       start,
    input  logic [3:0] op_a,
    input  logic [3:0] op_b,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       cout
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Returns {carry, sum} of one bit position.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    state_t     state;
    state_t     state_nx;
    logic [3:0] sh_a;
    logic [3:0] sh_b;
    logic       carry;
    logic [1:0] cnt;
    logic [1:0] bit_fa;
    logic       accept;
    logic       last_bit;

    assign {c, sum} = full_add(a, b, cin);

    assign bit_fa   = full_add(sh_a[0], sh_b[0], carry);
    assign busy     = (state == RUN);
    assign accept   = (state == IDLE) && start;
    assign last_bit = (state == RUN) && (cnt == 2'd3);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == 2'd3) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= last_bit;
        end
    end

    // Datapath: load on accepted start, one bit per clock while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a   <= 4'd0;
            sh_b   <= 4'd0;
            carry  <= 1'b0;
            cnt    <= 2'd0;
            result <= 4'd0;
            cout   <= 1'b0;
        end else if (accept) begin
            sh_a   <= op_a;
            sh_b   <= op_b;
            carry  <= cin;
            cnt    <= 2'd0;
            result <= 4'd0;
            cout   <= 1'b0;
        end else if (state == RUN) begin
            result <= {bit_fa[0], result[3:1]};
            carry  <= bit_fa[1];
            sh_a   <= {1'b0, sh_a[3:1]};
            sh_b   <= {1'b0, sh_b[3:1]};
            cnt    <= cnt + 2'd1;
            if (last_bit) cout <= bit_fa[1];
        end
    end

endmodule

// File: tb/tb_adder.sv
// Directed bench for adder: slice truth table, serial adds checked through a result queue,
// ignored start while busy, back-to-back start, and reset abort.
module tb_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0, b = 1'b0, cin = 1'b0;
    logic       sum, c;
    logic       start = 1'b0;
    logic [3:0] op_a = 4'd0, op_b = 4'd0;
    logic       busy, done;
    logic [3:0] result;
    logic       cout;

    int n_checks = 0;
    int n_fails  = 0;
    logic [4:0] sb[$];

    adder dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sum(sum), .c(c),
        .start(start), .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .result(result), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [3:0] x, input logic [3:0] y, input logic ci);
        @(negedge clk);
        op_a  = x;
        op_b  = y;
        cin   = ci;
        start = 1'b1;
        sb.push_back(5'(x) + 5'(y) + 5'(ci));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles from the current negedge until done, then scores the result.
    task automatic collect(input string tag, input int exp_busy);
        int bcnt = 0;
        logic seen = 1'b0;
        logic [4:0] exp;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
        if (!seen) begin
            check({tag, "_done_timeout"}, 8'd0, 8'd1);
        end else if (sb.size() == 0) begin
            check({tag, "_unexpected_done"}, 8'd1, 8'd0);
        end else begin
            exp = sb.pop_front();
            check({tag, "_result"}, 8'(result), 8'(exp[3:0]));
            check({tag, "_cout"}, 8'(cout), 8'(exp[4]));
            check({tag, "_busy_cycles"}, 8'(bcnt), 8'(exp_busy));
        end
    endtask

    task automatic quiet(input string tag, input int n);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check({tag, "_no_extra_done"}, 8'(pulses), 8'd0);
    endtask

    initial begin
        logic [2:0] vec;
        logic [1:0] exp_sc [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

        #2;
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_result", 8'(result), 8'd0);
        check("rst_cout", 8'(cout), 8'd0);

        // Slice truth table, order (a,b,cin) = 000,100,010,110,001,101,011,111.
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            a   = vec[0];
            b   = vec[1];
            cin = vec[2];
            #10;
            check($sformatf("slice_%0d%0d%0d", a, b, cin), 8'({sum, c}), 8'(exp_sc[i]));
        end
        cin = 1'b0;

        @(negedge clk);
        rst_n = 1'b1;

        launch(4'd5, 4'd6, 1'b0);
        collect("add_5_6", 4);
        quiet("add_5_6", 3);

        launch(4'd15, 4'd1, 1'b0);
        collect("add_15_1", 4);

        launch(4'd15, 4'd15, 1'b1);
        collect("add_15_15_c1", 4);
        quiet("add_15_15_c1", 2);

        // New operands pulsed mid-operation must be ignored.
        launch(4'd5, 4'd6, 1'b0);
        @(negedge clk);
        op_a  = 4'd1;
        op_b  = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect("ignored_start", 2);
        quiet("ignored_start", 6);
        check("ignored_start_idle", 8'(busy), 8'd0);

        // Start held high across completion re-launches with the operands present then.
        @(negedge clk);
        op_a  = 4'd2;
        op_b  = 4'd3;
        cin   = 1'b0;
        start = 1'b1;
        sb.push_back(5'd5);
        collect("b2b_first", 4);
        op_a = 4'd7;
        op_b = 4'd8;
        sb.push_back(5'd15);
        @(negedge clk);
        start = 1'b0;
        collect("b2b_second", 4);

        // Reset in the middle of 9+9 aborts it with no done.
        launch(4'd9, 4'd9, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check("abort_busy", 8'(busy), 8'd0);
        check("abort_done", 8'(done), 8'd0);
        check("abort_result", 8'(result), 8'd0);
        check("abort_cout", 8'(cout), 8'd0);
        quiet("abort_in_reset", 2);
        rst_n = 1'b1;
        quiet("abort_after_release", 6);

        launch(4'd3, 4'd4, 1'b0);
        collect("add_3_4", 4);
        check("queue_empty", 8'(sb.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
